am_access_scheduler: RTL

- Sits between the core issue stage and the AM access router that feeds the two dual-port AM banks.
- Accepts one operation at a time. An operation is a subset of {src0, src1, src2 read; dst write}.
- Checks per-bank port capacity: bank = addr[BANK_BIT], 2 ports per bank. If capacity is exceeded, the operation is split into two issue phases.
- Captures the read data, which returns one cycle after issue, and returns it through a valid/ready response.

---
 rtl/am_access_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/am_access_scheduler.sv
// Issue scheduler between the core and the AM access router: checks per-bank
// port capacity, splits over-subscribed operations into two phases, and returns
// captured read data over a valid/ready response.
// Optional performance counters are enabled by defining AM_SCHED_PERF_EN.
module am_access_scheduler #(
  parameter int P        = 64,
  parameter int W        = 8,
  parameter int BANK_BIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [2:0]         op_ren,
  input  logic               op_wen,
  input  logic [19:0]        op_addr,
  input  logic [4*P-1:0]     op_cs,
  input  logic [P*W-1:0]     op_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [3*P*W-1:0]   rsp_rdata,
  output logic [2:0]         am_ren,
  output logic               am_wen,
  output logic [19:0]        am_addr,
  output logic [4*P-1:0]     am_cs,
  output logic [P*W-1:0]     am_dst_wdata,
  input  logic [3*P*W-1:0]   am_rdata,
  output logic               busy,
  output logic [31:0]        perf_op_cnt,
  output logic [31:0]        perf_split_cnt
);

  localparam int RW = P * W;

  typedef enum logic [2:0] {IDLE, ISSUE1, ISSUE2, CAP, RSP} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              cap_en;
  logic [2:0]        ren_nxt;
  logic              wen_nxt;
  logic [2:0]        ren_q;
  logic [2:0]        p1_in;
  logic [2:0]        p2_q;
  logic              wen_q;
  logic              split_in;
  logic              split_q;
  logic              src1_blocked;
  logic [2:0]        cnt_b0, cnt_b1;
  logic [19:0]       addr_q;
  logic [4*P-1:0]    cs_q;
  logic [RW-1:0]     wdata_q;
  logic [3*RW-1:0]   rdata_q;

  assign accept = op_valid && (state == IDLE);

  always_comb begin
    cnt_b0 = '0;
    cnt_b1 = '0;
    for (int i = 0; i < 3; i++) begin
      if (op_ren[i]) begin
        if (op_addr[5*i+BANK_BIT]) cnt_b1 = cnt_b1 + 3'd1;
        else                       cnt_b0 = cnt_b0 + 3'd1;
      end
    end
    if (op_wen) begin
      if (op_addr[15+BANK_BIT]) cnt_b1 = cnt_b1 + 3'd1;
      else                      cnt_b0 = cnt_b0 + 3'd1;
    end
    split_in = (cnt_b0 > 3'd2) || (cnt_b1 > 3'd2);
    // Admission order src2, src0, src1: the first two always fit, so src1 only
    // waits when src2 and src0 already occupy both ports of its bank.
    src1_blocked = op_ren[2] && op_ren[0] &&
                   (op_addr[10+BANK_BIT] == op_addr[5+BANK_BIT]) &&
                   (op_addr[BANK_BIT]    == op_addr[5+BANK_BIT]);
    p1_in = split_in ? {op_ren[2], op_ren[1] & ~src1_blocked, op_ren[0]} : op_ren;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ren_nxt   = '0;
    wen_nxt   = 1'b0;
    op_ready  = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    cap_en    = 1'b0;
    unique case (state)
      IDLE: begin
        op_ready = 1'b1;
        busy     = 1'b0;
        if (op_valid) begin
          state_nxt = ISSUE1;
          ren_nxt   = p1_in;
          wen_nxt   = op_wen & ~split_in;
        end
      end
      ISSUE1: begin
        if (split_q) begin
          state_nxt = ISSUE2;
          ren_nxt   = p2_q;
          wen_nxt   = wen_q;
        end else begin
          state_nxt = CAP;
        end
      end
      ISSUE2: begin
        cap_en    = 1'b1;
        state_nxt = CAP;
      end
      CAP: begin
        cap_en    = 1'b1;
        state_nxt = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ren_q is the enable pattern issued last cycle, i.e. the slots whose data is on am_rdata now.
  always_ff @(posedge clk) begin
    if (rst) begin
      am_ren  <= '0;
      am_wen  <= 1'b0;
      ren_q   <= '0;
      p2_q    <= '0;
      wen_q   <= 1'b0;
      split_q <= 1'b0;
      addr_q  <= '0;
      cs_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      am_ren <= ren_nxt;
      am_wen <= wen_nxt;
      ren_q  <= am_ren;
      if (accept) begin
        addr_q  <= op_addr;
        cs_q    <= op_cs;
        wdata_q <= op_wdata;
        split_q <= split_in;
        p2_q    <= op_ren & ~p1_in;
        wen_q   <= op_wen;
        rdata_q <= '0;
      end
      if (cap_en) begin
        for (int i = 0; i < 3; i++) begin
          if (ren_q[i]) rdata_q[i*RW +: RW] <= am_rdata[i*RW +: RW];
        end
      end
    end
  end

  assign am_addr      = addr_q;
  assign am_cs        = cs_q;
  assign am_dst_wdata = wdata_q;
  assign rsp_rdata    = rdata_q;

`ifdef AM_SCHED_PERF_EN
  logic [31:0] op_cnt_q, split_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt_q    <= '0;
      split_cnt_q <= '0;
    end else begin
      if (rsp_valid && rsp_ready) op_cnt_q    <= op_cnt_q + 32'd1;
      if (accept && split_in)     split_cnt_q <= split_cnt_q + 32'd1;
    end
  end

  assign perf_op_cnt    = op_cnt_q;
  assign perf_split_cnt = split_cnt_q;
`else
  assign perf_op_cnt    = '0;
  assign perf_split_cnt = '0;
`endif

endmodule
